// File: rtl/uart_rx_axis_bridge.sv
// ============================================================================
//  Module   : uart_rx_axis_bridge
//  Purpose  : Buffers bytes from uart_rec and drains them as an AXI-Stream
//             master, marking packet ends on idle timeout or (optionally,
//             macro UART_RX_DELIM_EN) on a delimiter byte.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_axis_bridge #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 16,
    parameter int               CLK_RATE   = 50000000,
    parameter int               BAUD       = 115200,
    parameter int               IDLE_CHARS = 2,
    parameter logic [WIDTH-1:0] DELIM      = WIDTH'(8'h0A)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_parity_err,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    output logic                       m_axis_last,
    input  logic                       m_axis_ready,
    output logic                       overflow,
    output logic [7:0]                 err_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int BAUD_DIV = CLK_RATE / BAUD;
    localparam int TIMEOUT  = IDLE_CHARS * 11 * BAUD_DIV;
    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int MEM_N    = DEPTH - 1;
    localparam int PW       = (MEM_N > 1) ? $clog2(MEM_N) : 1;
    localparam int CW       = $clog2(DEPTH);
    localparam int LW       = $clog2(DEPTH) + 1;

    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(MEM_N - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // ------------------------------------------------------------------
    // Staging register and idle timer
    // ------------------------------------------------------------------
    logic             stg_v_q, stg_v_d;
    logic [WIDTH-1:0] stg_d_q, stg_d_d;
    logic             stg_close_q, stg_close_d;
    logic [TW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             push_last;
    logic             is_delim;
    logic             good_byte;

`ifdef UART_RX_DELIM_EN
    assign is_delim = (rx_data == DELIM);
`else
    assign is_delim = 1'b0;
`endif

    // A parity error on the same strobe overrides the byte.
    assign good_byte = rx_valid & ~rx_parity_err;

    always_comb begin
        push        = 1'b0;
        push_data   = stg_d_q;
        push_last   = stg_close_q;
        stg_v_d     = stg_v_q;
        stg_d_d     = stg_d_q;
        stg_close_d = stg_close_q;

        if (good_byte) begin
            push        = stg_v_q;
            push_last   = stg_close_q;
            stg_v_d     = 1'b1;
            stg_d_d     = rx_data;
            stg_close_d = is_delim;
        end else if (!rx_valid && stg_v_q &&
                     (stg_close_q || (idle_cnt_q == IDLE_MAX))) begin
            push        = 1'b1;
            push_last   = 1'b1;
            stg_v_d     = 1'b0;
            stg_close_d = 1'b0;
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (rx_valid || rx_parity_err || !stg_v_q) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + TW'(1);
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rx_parity_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Storage: head output register in front of a DEPTH-1 entry ring
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mem_q [MEM_N];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
    logic             head_v_q, head_v_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_last_q, head_last_d;
    logic             ovf_q, ovf_d;
    logic             mem_we;
    logic             full;
    logic             accept;
    logic             pop;
    logic             mem_empty;
    logic [WIDTH:0]   mem_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign level     = LW'(head_v_q) + LW'(mem_cnt_q);
    assign full      = (level == FULL_LVL);
    assign accept    = push & ~full;
    assign pop       = head_v_q & m_axis_ready;
    assign mem_empty = (mem_cnt_q == '0);
    assign mem_rd    = mem_q[rd_ptr_q];

    always_comb begin
        head_v_d    = head_v_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_cnt_d   = mem_cnt_q;
        mem_we      = 1'b0;
        // Overflow is judged on the occupancy at the start of the cycle,
        // so a simultaneous pop does not rescue the incoming entry.
        ovf_d       = ovf_q | (push & full);

        if (pop) begin
            if (!mem_empty) begin
                head_data_d = mem_rd[WIDTH-1:0];
                head_last_d = mem_rd[WIDTH];
                rd_ptr_d    = ptr_inc(rd_ptr_q);
                if (accept) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end else begin
                    mem_cnt_d = mem_cnt_q - CW'(1);
                end
            end else if (accept) begin
                head_data_d = push_data;
                head_last_d = push_last;
            end else begin
                head_v_d = 1'b0;
            end
        end else if (accept) begin
            if (!head_v_q) begin
                head_v_d    = 1'b1;
                head_data_d = push_data;
                head_last_d = push_last;
            end else begin
                mem_we    = 1'b1;
                wr_ptr_d  = ptr_inc(wr_ptr_q);
                mem_cnt_d = mem_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_v_q     <= 1'b0;
            stg_d_q     <= '0;
            stg_close_q <= 1'b0;
            idle_cnt_q  <= '0;
            err_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            head_v_q    <= 1'b0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            stg_v_q     <= stg_v_d;
            stg_d_q     <= stg_d_d;
            stg_close_q <= stg_close_d;
            idle_cnt_q  <= idle_cnt_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            head_v_q    <= head_v_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            ovf_q       <= ovf_d;
        end
    end

    assign m_axis_valid = head_v_q;
    assign m_axis_data  = head_data_q;
    assign m_axis_last  = head_last_q;
    assign overflow     = ovf_q;
    assign err_cnt      = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_axis_bridge.sv
// ============================================================================
//  Module   : tb_uart_rx_axis_bridge
//  Purpose  : Directed + randomized bench for uart_rx_axis_bridge with a
//             transaction-level packet model and stream scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_axis_bridge;

    localparam int         WIDTH      = 8;
    localparam int         DEPTH      = 16;
    localparam int         CLK_RATE   = 1000000;
    localparam int         BAUD       = 100000;
    localparam int         IDLE_CHARS = 2;
    localparam logic [7:0] DELIM      = 8'h0A;
    localparam int         TIMEOUT    = IDLE_CHARS * 11 * (CLK_RATE / BAUD);
`ifdef UART_RX_DELIM_EN
    localparam bit DELIM_ON = 1'b1;
`else
    localparam bit DELIM_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [WIDTH-1:0]        rx_data;
    logic                    rx_valid;
    logic                    rx_parity_err;
    logic [WIDTH-1:0]        m_axis_data;
    logic                    m_axis_valid;
    logic                    m_axis_last;
    logic                    m_axis_ready;
    logic                    overflow;
    logic [7:0]              err_cnt;
    logic [$clog2(DEPTH):0]  level;

    uart_rx_axis_bridge #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CLK_RATE(CLK_RATE), .BAUD(BAUD),
        .IDLE_CHARS(IDLE_CHARS), .DELIM(DELIM)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
        .overflow(overflow), .err_cnt(err_cnt), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0;
    int nchk = 0;

    // Expected stream contents, {last, data}, in emission order.
    logic [8:0] exp_q [$];
    bit         pend;
    bit         pend_close;
    logic [7:0] pend_d;
    int         since;
    int         errm;
    bit         ovfm;
    bit         mon_en = 1'b0;
    bit         rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_push(input logic [7:0] d, input bit l);
        if (exp_q.size() >= DEPTH) ovfm = 1'b1;
        else exp_q.push_back({l, d});
    endfunction

    function automatic void m_reset();
        exp_q.delete();
        pend = 0; pend_close = 0; pend_d = '0; since = 0; errm = 0; ovfm = 0;
    endfunction

    // Packet rules: a byte is released when its successor arrives, when it
    // was a delimiter, or when the line has been quiet for TIMEOUT cycles.
    function automatic void m_cycle(input logic [7:0] d, input bit vld, input bit perr);
        if (!vld) begin
            if (pend) begin
                if (pend_close) begin
                    m_push(pend_d, 1'b1); pend = 0;
                end else begin
                    since++;
                    if (since == TIMEOUT) begin m_push(pend_d, 1'b1); pend = 0; end
                end
            end
        end else if (!perr) begin
            if (pend) m_push(pend_d, pend_close);
            pend = 1; pend_d = d; pend_close = DELIM_ON && (d == DELIM);
        end
        if (vld || perr) since = 0;
        if (perr && errm < 255) errm++;
    endfunction

    task automatic step(input logic [7:0] d, input bit vld, input bit perr);
        rx_data = d; rx_valid = vld; rx_parity_err = perr;
        if (rand_ready) m_axis_ready = 1'($urandom_range(0, 1));
        m_cycle(d, vld, perr);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h00, 1'b0, 1'b0);
    endtask

    // Stream monitor: scoreboard every handshake and hold-stable stalls.
    bit         prev_stall = 0;
    logic [7:0] prev_d;
    logic       prev_l;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (prev_stall)
                    chk("stall_hold", {m_axis_valid, m_axis_last, m_axis_data}, {1'b1, prev_l, prev_d});
                if (m_axis_valid) begin
                    if (exp_q.size() == 0) chk("spurious_valid", m_axis_valid, 0);
                    else if (m_axis_ready) chk("beat", {m_axis_last, m_axis_data}, exp_q.pop_front());
                end
                prev_stall = m_axis_valid && !m_axis_ready;
                prev_d = m_axis_data;
                prev_l = m_axis_last;
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        int s;
        int lat;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_parity_err = 1'b0; m_axis_ready = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {m_axis_valid, m_axis_last, m_axis_data, overflow, err_cnt}, 0);
        chk("rst_level", level, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Three bytes inside one packet, closed by idle timeout.
        m_axis_ready = 1'b1;
        step(8'h11, 1, 0); idle(TIMEOUT / 2 - 1);
        step(8'h22, 1, 0); idle(TIMEOUT / 2 - 1);
        s = cyc;
        step(8'h33, 1, 0);
        lat = -1;
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            if (lat < 0 && m_axis_valid && m_axis_last) lat = cyc - s;
            step(8'h00, 0, 0);
        end
        chk("timeout_latency", lat, TIMEOUT + 1);
        chk("t1_drained", exp_q.size(), 0);

        // Delimiter byte closes the packet only when the feature is built.
        step(8'h41, 1, 0); idle(3);
        s = cyc;
        step(DELIM, 1, 0);
        idle(1);
        chk("delim_cycle", cyc - s, 2);
        if (DELIM_ON) chk("delim_beat", {m_axis_valid, m_axis_last, m_axis_data}, {1'b1, 1'b1, DELIM});
        else          chk("no_delim_close", m_axis_valid, 0);
        idle(TIMEOUT + 5);
        chk("t2_drained", exp_q.size(), 0);

        // Overflow: 20 bytes into a stalled stream.
        m_axis_ready = 1'b0;
        for (int i = 0; i < 20; i++) step(8'($urandom), 1, 0);
        idle(TIMEOUT + 5);
        chk("level_full", level, DEPTH);
        chk("overflow_set", overflow, ovfm);
        chk("overflow_one", overflow, 1);
        rand_ready = 1'b1; idle(60); rand_ready = 1'b0;
        m_axis_ready = 1'b1; idle(20);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_level0", level, 0);
        chk("overflow_sticky", overflow, 1);

        // Parity errors interleaved with good bytes, one coinciding strobe.
        step(8'hEE, 0, 1);
        step(8'h55, 1, 0);
        step(8'hEE, 0, 1);
        step(8'h66, 1, 0);
        step(8'h77, 1, 1);
        idle(TIMEOUT + 5);
        chk("err_cnt3", err_cnt, errm);
        chk("err_cnt3_abs", err_cnt, 3);
        chk("perr_drained", exp_q.size(), 0);
        for (int i = 0; i < 300; i++) step(8'($urandom), 0, 1);
        chk("err_sat", err_cnt, 255);

        // Reset with five stored bytes and a loaded stage.
        m_axis_ready = 1'b0;
        for (int i = 0; i < 6; i++) step(8'($urandom), 1, 0);
        chk("pre_rst_level", level, 5);
        rst = 1'b1;
        m_reset();
        @(posedge clk); #1;
        chk("rst_valid", m_axis_valid, 0);
        chk("rst_level2", level, 0);
        chk("rst_ovf_err", {overflow, err_cnt}, 0);
        rst = 1'b0;
        m_axis_ready = 1'b1;
        idle(TIMEOUT + 10);
        chk("post_rst_level", level, 0);

        // Single-byte packets across pointer wrap with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(8'($urandom), 1, 0);
            idle(TIMEOUT + $urandom_range(1, 8));
        end
        rand_ready = 1'b0;
        m_axis_ready = 1'b1;
        idle(30);
        chk("wrap_drained", exp_q.size(), 0);
        chk("wrap_level", level, 0);
        chk("final_overflow", overflow, ovfm);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_axis_bridge.md
# uart_rx_axis_bridge

Receive-side packetiser that sits directly downstream of `uart_rec`. It consumes decoded bytes (`rx_data`/`rx_valid`) and the parity-error pulse, and buffers good bytes in a synchronous FIFO. It drains them as an AXI-Stream master, setting `m_axis_last` on the final byte of each packet. A packet ends on an idle-line timeout, or on a delimiter byte when the delimiter feature is compiled in.

## Interface
Parameters:
- `WIDTH`, 8: data byte width.
- `DEPTH`, 16: total storage in entries, including the output register; power of two, ≥ 2.
- `CLK_RATE`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: line rate.
- `IDLE_CHARS`, 2: idle character times that close an open packet.
- `DELIM`, 8'h0A: delimiter byte; used only with `UART_RX_DELIM_EN`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  WIDTH  byte from `uart_rec`.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` is good.
- `rx_parity_err`  in  1  one-cycle strobe: the byte just received failed parity.
- `m_axis_data`  out  WIDTH  stream data.
- `m_axis_valid`  out  1  stream valid.
- `m_axis_last`  out  1  final byte of the packet.
- `m_axis_ready`  in  1  downstream ready.
- `overflow`  out  1  sticky flag: a byte was dropped because storage was full.
- `err_cnt`  out  8  count of parity errors, saturating at 255.
- `level`  out  $clog2(DEPTH)+1  occupied entries, including the output register.

## Operation
- `BAUD_DIV = CLK_RATE/BAUD`.
- `TIMEOUT = IDLE_CHARS*11*BAUD_DIV`, where 11 bits = start + 8 data + parity + stop. Default: 2*11*434 = 9548.
- Staging register holds the newest byte (`stg_v`, `stg_d`, `stg_close`), so `last` can be attached after the fact.
- `rx_valid` cycle, rules in priority order:
  - If `stg_v`, push {`stg_d`, last=`stg_close`}.
  - Load the stage with `rx_data`; `stg_v`=1.
  - `stg_close`=1 iff the delimiter feature is on and `rx_data`==`DELIM`.
- Close cycle (`stg_v` & `stg_close` & !`rx_valid`): push {`stg_d`, 1}; `stg_v`=0.
- Timeout cycle (`stg_v` & !`stg_close` & `idle_cnt`==`TIMEOUT`-1 & !`rx_valid`): push {`stg_d`, 1}; `stg_v`=0.
- `idle_cnt`:
  - Clears on `rx_valid`, `rx_parity_err`, or !`stg_v`.
  - Otherwise increments, saturating at `TIMEOUT`-1.
- `rx_parity_err`:
  - Byte is discarded; stage is untouched.
  - `err_cnt`+1, saturating at 255.
  - If `rx_valid` and `rx_parity_err` coincide, the error wins and the byte is dropped.
- Push rules:
  - A push when `level`==`DEPTH` (value at the start of the cycle) drops the entry and sets `overflow`. This holds even if a pop happens in the same cycle.
  - `overflow` clears only on `rst`.
- FIFO: circular buffer with `wr_ptr`/`rd_ptr` wrapping modulo `DEPTH`-1, plus a head output register.
  - `level` = (head valid) + memory count.
  - Push and pop in the same cycle leave `level` unchanged.
- AXIS rules:
  - `m_axis_data`/`m_axis_last` are driven from the head register.
  - They stay stable while `m_axis_valid` & !`m_axis_ready`.
  - `m_axis_valid` never drops without a handshake.
  - On a handshake, the head reloads from memory in the same edge if memory is non-empty; otherwise `m_axis_valid` goes to 0.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `m_axis_valid`=0, `m_axis_last`=0, `m_axis_data`=0.
  - `overflow`=0, `err_cnt`=0, `level`=0.
  - Stage, pointers and `idle_cnt` cleared.
- `rst` mid-packet discards the stage and all stored bytes; no `last` is emitted for the discarded data.
- Push in cycle N into empty storage: `m_axis_valid`=1 at N+1.
- Latency from `rx_valid` to a byte on the stream:
  - Normal case: one byte-time, since a byte leaves the stage only when the next byte arrives.
  - Delimiter case: 2 cycles.
  - Timeout case: `TIMEOUT`+1 cycles.
- Throughput: one pop per cycle while `m_axis_ready`=1.

## Configuration
- Macro: `UART_RX_DELIM_EN`.
- Defined: a received byte equal to `DELIM` closes the packet; it is emitted with `last`=1 and the timeout still applies.
- Undefined: `stg_close` is tied to 0; only the idle timeout ends packets, and `DELIM` is ignored.

## Test plan
- Send 3 bytes 0x11, 0x22, 0x33 spaced 4774 cycles, `m_axis_ready`=1 -> stream 0x11 (last 0), 0x22 (last 0), 0x33 (last 1); 0x33 appears 9549 cycles after its strobe.
- Delimiter build, send 0x41, 0x0A -> 0x41 (last 0) when 0x0A arrives, then 0x0A (last 1) 2 cycles after its strobe.
- `m_axis_ready`=0, push 20 bytes with DEPTH 16 -> `level`=16, `overflow`=1, bytes 17–20 dropped. Ready high -> first 16 bytes emitted in order, with data held stable during the stall.
- Three `rx_parity_err` pulses among 2 good bytes -> `err_cnt`=3, stream carries only the 2 good bytes; 300 error pulses -> `err_cnt` saturates at 255.
- `rst` asserted while 5 bytes are stored and the stage is full -> next cycle `m_axis_valid`=0 and `level`=0; no stale byte appears afterwards.
- Pointer wrap: 40 single-byte packets through DEPTH 16 with random `m_axis_ready` -> every byte emitted once, in order, each with `last`=1.
